// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART register slave.
// Holds default timing constants, the slave FSM state encoding and the
// odd-parity helper used by both the receiver and the reply serializer.
package uart_pkg;

    localparam int CLKS_PER_BIT_DEF   = 434;
    localparam int TURNAROUND_DEF     = 100;
    localparam int TIMEOUT_CYCLES_DEF = 8680;

    // Slave FSM states, 3-bit encoding
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_DATA = 3'd1,
        S_TURN      = 3'd2,
        S_TX_START  = 3'd3,
        S_TX_DATA   = 3'd4,
        S_TX_PAR    = 3'd5,
        S_TX_STOP   = 3'd6
    } slave_state_t;

    // Odd parity bit: data plus parity always holds an odd number of ones
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: single-byte UART receiver (start, 8 data LSB-first, parity, stop).
// rx is synchronised by two flops; a frame starts on a synchronised falling edge
// and every bit is sampled at mid-bit. A start bit sampled high is a false start
// and is dropped silently. o_byte_valid pulses once per frame at the stop sample.
// With UART_SLAVE_TIMEOUT_EN defined, o_busy reports a frame in progress.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_rx,
`ifdef UART_SLAVE_TIMEOUT_EN
    output logic       o_busy,
`endif
    output logic       o_byte_valid,
    output logic [7:0] o_data,
    output logic       o_par_ok,
    output logic       o_stop_ok
);

    localparam int               CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] MID   = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_prev;
    logic             r_active;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_bit;     // 0 start, 1..8 data, 9 parity, 10 stop
    logic [7:0]       r_shift;
    logic             r_par;
    logic             w_fall;

    assign w_fall = r_prev & ~r_sync2;

`ifdef UART_SLAVE_TIMEOUT_EN
    assign o_busy = r_active;
`endif

    // Two-flop synchroniser plus a delayed copy for falling-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= i_rx;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // Bit timing, mid-bit sampling and byte hand-off
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active     <= 1'b0;
            r_cnt        <= '0;
            r_bit        <= 4'd0;
            r_shift      <= 8'h00;
            r_par        <= 1'b0;
            o_byte_valid <= 1'b0;
            o_data       <= 8'h00;
            o_par_ok     <= 1'b0;
            o_stop_ok    <= 1'b0;
        end else begin
            o_byte_valid <= 1'b0;
            if (!r_active) begin
                if (w_fall) begin
                    r_active <= 1'b1;
                    r_cnt    <= '0;
                    r_bit    <= 4'd0;
                end
            end else begin
                if (r_cnt == LAST) begin
                    r_cnt <= '0;
                    r_bit <= r_bit + 4'd1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                if (r_cnt == MID) begin
                    if (r_bit == 4'd0) begin
                        if (r_sync2) begin
                            r_active <= 1'b0;
                        end
                    end else if (r_bit <= 4'd8) begin
                        r_shift <= {r_sync2, r_shift[7:1]};
                    end else if (r_bit == 4'd9) begin
                        r_par <= r_sync2;
                    end else begin
                        // Return to hunting mid-stop so a back-to-back start edge is caught
                        o_byte_valid <= 1'b1;
                        o_data       <= r_shift;
                        o_par_ok     <= (r_par == odd_parity(r_shift));
                        o_stop_ok    <= r_sync2;
                        r_active     <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/uart_reg_slave.sv
// uart_reg_slave: device-side UART register slave.
// Byte0 = {rw, addr}. rw=1 expects a data byte and writes the register file;
// rw=0 snapshots the addressed register and replies with one frame on tx after
// a fixed idle-high turnaround. Bytes arriving while a reply is pending or in
// flight are ignored (half-duplex). dbg_state exposes the FSM state.
// Optional: define UART_SLAVE_TIMEOUT_EN to abandon a write whose data byte
// does not start within TIMEOUT_CYCLES.
module uart_reg_slave
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT   = CLKS_PER_BIT_DEF,
    parameter int TURNAROUND     = TURNAROUND_DEF,
`ifdef UART_SLAVE_TIMEOUT_EN
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
`endif
    parameter int ADDR_WIDTH     = 7,
    parameter int DATA_WIDTH     = 8
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx,
    output logic                  tx,
    output logic                  reg_wr_valid,
    output logic [ADDR_WIDTH-1:0] reg_wr_addr,
    output logic [DATA_WIDTH-1:0] reg_wr_data,
    output logic                  frame_err,
    output logic [2:0]            dbg_state
);

    localparam int               CNT_MAX   = (CLKS_PER_BIT > TURNAROUND) ? CLKS_PER_BIT : TURNAROUND;
    localparam int               CNT_W     = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURNAROUND - 1);

    logic                  w_byte_valid;
    logic [7:0]            w_rx_data;
    logic                  w_par_ok;
    logic                  w_stop_ok;
    logic                  w_byte_ok;

    slave_state_t          r_state;
    logic [DATA_WIDTH-1:0] r_regs [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_tx_shift;
    logic                  r_tx_par;
    logic [CNT_W-1:0]      r_cnt;
    logic [2:0]            r_bit_cnt;

`ifdef UART_SLAVE_TIMEOUT_EN
    localparam int             GAP_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);
    logic                      w_rx_busy;
    logic [GAP_W-1:0]          r_gap_cnt;
`endif

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_rx         (rx),
`ifdef UART_SLAVE_TIMEOUT_EN
        .o_busy       (w_rx_busy),
`endif
        .o_byte_valid (w_byte_valid),
        .o_data       (w_rx_data),
        .o_par_ok     (w_par_ok),
        .o_stop_ok    (w_stop_ok)
    );

    assign w_byte_ok = w_par_ok & w_stop_ok;
    assign dbg_state = r_state;

    // Slave FSM: command decode, register file, reply serializer, write timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            tx           <= 1'b1;
            reg_wr_valid <= 1'b0;
            reg_wr_addr  <= '0;
            reg_wr_data  <= '0;
            frame_err    <= 1'b0;
            r_addr       <= '0;
            r_tx_shift   <= '0;
            r_tx_par     <= 1'b0;
            r_cnt        <= '0;
            r_bit_cnt    <= 3'd0;
            for (int i = 0; i < 2**ADDR_WIDTH; i++) begin
                r_regs[i] <= '0;
            end
`ifdef UART_SLAVE_TIMEOUT_EN
            r_gap_cnt    <= '0;
`endif
        end else begin
            reg_wr_valid <= 1'b0;
            frame_err    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_byte_valid) begin
                        if (!w_byte_ok) begin
                            frame_err <= 1'b1;
                        end else if (w_rx_data[7]) begin
                            r_addr  <= w_rx_data[ADDR_WIDTH-1:0];
                            r_state <= S_WAIT_DATA;
`ifdef UART_SLAVE_TIMEOUT_EN
                            r_gap_cnt <= '0;
`endif
                        end else begin
                            // Snapshot now so later writes cannot change the reply
                            r_addr     <= w_rx_data[ADDR_WIDTH-1:0];
                            r_tx_shift <= r_regs[w_rx_data[ADDR_WIDTH-1:0]];
                            r_tx_par   <= odd_parity(r_regs[w_rx_data[ADDR_WIDTH-1:0]]);
                            r_cnt      <= '0;
                            r_state    <= S_TURN;
                        end
                    end
                end
                S_WAIT_DATA: begin
                    if (w_byte_valid) begin
                        if (w_byte_ok) begin
                            r_regs[r_addr] <= w_rx_data;
                            reg_wr_valid   <= 1'b1;
                            reg_wr_addr    <= r_addr;
                            reg_wr_data    <= w_rx_data;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        r_state <= S_IDLE;
                    end
`ifdef UART_SLAVE_TIMEOUT_EN
                    else if (!w_rx_busy) begin
                        if (r_gap_cnt == GAP_LAST) begin
                            frame_err <= 1'b1;
                            r_state   <= S_IDLE;
                        end else begin
                            r_gap_cnt <= r_gap_cnt + 1'b1;
                        end
                    end
`endif
                end
                S_TURN: begin
                    if (r_cnt == TURN_LAST) begin
                        r_cnt   <= '0;
                        tx      <= 1'b0;
                        r_state <= S_TX_START;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_TX_START: begin
                    if (r_cnt == BIT_LAST) begin
                        r_cnt     <= '0;
                        r_bit_cnt <= 3'd0;
                        tx        <= r_tx_shift[0];
                        r_state   <= S_TX_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_TX_DATA: begin
                    if (r_cnt == BIT_LAST) begin
                        r_cnt <= '0;
                        if (r_bit_cnt == 3'd7) begin
                            tx      <= r_tx_par;
                            r_state <= S_TX_PAR;
                        end else begin
                            r_bit_cnt  <= r_bit_cnt + 3'd1;
                            tx         <= r_tx_shift[1];
                            r_tx_shift <= r_tx_shift >> 1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_TX_PAR: begin
                    if (r_cnt == BIT_LAST) begin
                        r_cnt   <= '0;
                        tx      <= 1'b1;
                        r_state <= S_TX_STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_TX_STOP: begin
                    if (r_cnt == BIT_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    tx      <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_reg_slave.sv
// tb_uart_reg_slave: bench for uart_reg_slave with a shortened bit time.
// A byte-level model (register array, pending-write flag, expected queues)
// predicts writes, frame errors and reply frames; one negedge process checks
// the DUT against it every cycle. Build with +define+UART_SLAVE_TIMEOUT_EN to
// cover the write timeout instead of the indefinite wait.
`timescale 1ns/1ps
module tb_uart_reg_slave;
    import uart_pkg::*;

    localparam int C  = 40;    // clocks per bit in this bench
    localparam int TA = 100;   // turnaround cycles
`ifdef UART_SLAVE_TIMEOUT_EN
    localparam int TO = 8680;
`endif

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic        tx;
    logic        reg_wr_valid;
    logic [6:0]  reg_wr_addr;
    logic [7:0]  reg_wr_data;
    logic        frame_err;
    logic [2:0]  dbg_state;
    int          cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    uart_reg_slave #(
        .CLKS_PER_BIT   (C),
        .TURNAROUND     (TA)
`ifdef UART_SLAVE_TIMEOUT_EN
        , .TIMEOUT_CYCLES (TO)
`endif
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx           (rx),
        .tx           (tx),
        .reg_wr_valid (reg_wr_valid),
        .reg_wr_addr  (reg_wr_addr),
        .reg_wr_data  (reg_wr_data),
        .frame_err    (frame_err),
        .dbg_state    (dbg_state)
    );

    // ---------------- model and scoreboard ----------------
    typedef struct {
        logic [7:0] data;
        int         t_ref;   // cycle of the command's stop-bit middle
    } reply_t;

    int          total = 0;
    int          bad = 0;
    logic [7:0]  mdl_regs [128];
    bit          mdl_wait;
    logic [6:0]  mdl_addr;
    int          exp_err;
    logic [14:0] exp_wr_q [$];
    reply_t      exp_reply_q [$];
    logic [14:0] last_wr;
    logic [10:0] last_frame;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic par_of(input logic [7:0] d);
        return ($countones(d) % 2) == 0;   // make the total count of ones odd
    endfunction

    function automatic void mdl_clear();
        for (int i = 0; i < 128; i++) mdl_regs[i] = 8'h00;
        mdl_wait = 1'b0;
        mdl_addr = 7'd0;
        exp_err  = 0;
        exp_wr_q.delete();
        exp_reply_q.delete();
    endfunction

    // What one received byte does to the slave, at transaction level
    function automatic void mdl_byte(input logic [7:0] b, input bit good, input int t_ref);
        if (!good) begin
            exp_err++;
            mdl_wait = 1'b0;
        end else if (mdl_wait) begin
            mdl_regs[mdl_addr] = b;
            exp_wr_q.push_back({mdl_addr, b});
            mdl_wait = 1'b0;
        end else if (b[7]) begin
            mdl_wait = 1'b1;
            mdl_addr = b[6:0];
        end else begin
            exp_reply_q.push_back('{data: mdl_regs[b[6:0]], t_ref: t_ref});
        end
    endfunction

    // ---------------- compare process ----------------
    bit          tx_active = 1'b0;
    bit          tx_chk = 1'b0;
    int          tx_pos = 0;
    logic [10:0] tx_exp = 11'h7FF;

    always @(negedge clk) begin
        if (!rst_n) begin
            tx_active = 1'b0;
        end else begin
            if (reg_wr_valid) begin
                last_wr = {reg_wr_addr, reg_wr_data};
                if (exp_wr_q.size() == 0) begin
                    check("unexpected_write", {17'd0, reg_wr_addr, reg_wr_data}, 32'hFFFF_FFFF);
                end else begin
                    check("write_addr_data", {17'd0, reg_wr_addr, reg_wr_data}, {17'd0, exp_wr_q.pop_front()});
                end
            end
            if (frame_err) begin
                check("frame_err_expected", (exp_err > 0) ? 32'd1 : 32'd0, 32'd1);
                if (exp_err > 0) exp_err--;
            end
            if (!tx_active && tx === 1'b0) begin
                reply_t r;
                tx_active = 1'b1;
                tx_pos = 0;
                if (exp_reply_q.size() == 0) begin
                    check("unexpected_tx_start", 32'd1, 32'd0);
                    tx_chk = 1'b0;
                end else begin
                    r = exp_reply_q.pop_front();
                    tx_chk = 1'b1;
                    tx_exp = {1'b1, par_of(r.data), r.data, 1'b0};
                    total++;
                    if ((cyc - r.t_ref) < TA || (cyc - r.t_ref) > TA + 8) begin
                        bad++;
                        $display("FAIL tx_turnaround: got=%0d want=%0d..%0d", cyc - r.t_ref, TA, TA + 8);
                    end
                end
            end
            if (tx_active) begin
                if (tx_chk) check("tx_bit", {31'd0, tx}, {31'd0, tx_exp[tx_pos / C]});
                if (tx_pos % C == C / 2) last_frame[tx_pos / C] = tx;
                tx_pos++;
                if (tx_pos == 11 * C) tx_active = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] b, input bit flip_par, input bit bad_stop, input bit model);
        logic [10:0] f;
        logic        p;
        p = par_of(b) ^ flip_par;
        f = {~bad_stop, p, b, 1'b0};
        if (model) mdl_byte(b, !(flip_par || bad_stop), cyc + 10 * C + C / 2);
        for (int i = 0; i < 11; i++) begin
            rx = f[i];
            repeat (C) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic gap();
        repeat ($urandom_range(4, 2 * C)) @(negedge clk);
    endtask

    task automatic wait_reply();
        repeat (TA + 11 * C + 40) @(negedge clk);
    endtask

    task automatic checkpoint(input string tag);
        check({tag, "_writes_pending"}, exp_wr_q.size(), 0);
        check({tag, "_errs_pending"}, exp_err, 0);
        check({tag, "_replies_pending"}, exp_reply_q.size(), 0);
        check({tag, "_state"}, {29'd0, dbg_state}, mdl_wait ? {29'd0, S_WAIT_DATA} : {29'd0, S_IDLE});
    endtask

    task automatic do_write(input logic [6:0] a, input logic [7:0] d);
        send_byte({1'b1, a}, 1'b0, 1'b0, 1'b1);
        gap();
        send_byte(d, 1'b0, 1'b0, 1'b1);
        gap();
    endtask

    task automatic do_read(input logic [6:0] a);
        send_byte({1'b0, a}, 1'b0, 1'b0, 1'b1);
        wait_reply();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        mdl_clear();
        repeat (5) @(negedge clk);
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_wr_valid", {31'd0, reg_wr_valid}, 32'd0);
        check("reset_frame_err", {31'd0, frame_err}, 32'd0);
        check("reset_state", {29'd0, dbg_state}, {29'd0, S_IDLE});
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Model pins: odd parity of known bytes
        check("pin_par_3c", {31'd0, par_of(8'h3C)}, 32'd1);
        check("pin_par_01", {31'd0, par_of(8'h01)}, 32'd0);

        // Write 0x05 <= 0x3C, then read it back
        do_write(7'h05, 8'h3C);
        checkpoint("t1");
        check("t1_write_literal", {17'd0, last_wr}, {17'd0, 7'h05, 8'h3C});
        do_read(7'h05);
        checkpoint("t2");
        check("t2_frame_literal", {21'd0, last_frame}, {21'd0, 11'b11_00111100_0});

        // Bad parity on a command byte, then normal traffic resumes
        send_byte(8'h90, 1'b1, 1'b0, 1'b1);
        gap();
        checkpoint("t3_err");
        do_write(7'h10, 8'hA5);
        do_read(7'h10);
        checkpoint("t3");

        // Glitch shorter than half a bit: false start, nothing happens
        rx = 1'b0;
        repeat (C / 2 - 5) @(negedge clk);
        rx = 1'b1;
        repeat (2 * C) @(negedge clk);
        checkpoint("t4");

        // Byte sent during a reply is discarded; FSM must not enter a write
        send_byte(8'h05, 1'b0, 1'b0, 1'b1);
        send_byte(8'h8A, 1'b0, 1'b0, 1'b0);
        wait_reply();
        checkpoint("hd");
        do_write(7'h0A, 8'h77);
        do_read(7'h0A);
        checkpoint("hd2");

        // Asynchronous reset in the middle of a reply
        send_byte(8'h10, 1'b0, 1'b0, 1'b1);
        repeat (200) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_tx", {31'd0, tx}, 32'd1);
        check("midreset_state", {29'd0, dbg_state}, {29'd0, S_IDLE});
        mdl_clear();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Reads after reset return 0x00 (odd parity bit 1)
        do_read(7'h7F);
        check("t5_frame_literal", {21'd0, last_frame}, {21'd0, 11'b11_00000000_0});
        do_read(7'h10);
        checkpoint("t5");

        // Long gap between write command and data byte
        send_byte(8'h81, 1'b0, 1'b0, 1'b1);
`ifdef UART_SLAVE_TIMEOUT_EN
        exp_err++;
        mdl_wait = 1'b0;
        repeat (TO + 100) @(negedge clk);
        checkpoint("t6_timeout");
        do_read(7'h01);
        check("t6_frame_literal", {21'd0, last_frame}, {21'd0, 11'b11_00000000_0});
`else
        repeat (20000) @(negedge clk);
        checkpoint("t6_wait");
        send_byte(8'h55, 1'b0, 1'b0, 1'b1);
        gap();
        checkpoint("t6_late");
        do_read(7'h01);
        check("t6_frame_literal", {21'd0, last_frame}, {21'd0, 11'b11_01010101_0});
`endif
        checkpoint("t6");

        // Randomized traffic
        for (int n = 0; n < 24; n++) begin
            logic [6:0] a;
            int         kind;
            a = $urandom_range(0, 1) ? 7'($urandom_range(0, 7)) : 7'($urandom_range(0, 127));
            kind = $urandom_range(0, 5);
            case (kind)
                0, 1: begin
                    send_byte({1'b1, a}, 1'b0, 1'b0, 1'b1);
                    gap();
                    send_byte(8'($urandom_range(0, 255)), ($urandom_range(0, 5) == 0), 1'b0, 1'b1);
                    gap();
                end
                2, 3: do_read(a);
                4: begin
                    send_byte(8'($urandom_range(0, 255)), 1'b0, 1'b1, 1'b1);
                    gap();
                end
                default: begin
                    rx = 1'b0;
                    repeat ($urandom_range(1, C / 2 - 3)) @(negedge clk);
                    rx = 1'b1;
                    repeat (C) @(negedge clk);
                    gap();
                end
            endcase
            checkpoint("rnd");
        end

        repeat (10) @(negedge clk);
        checkpoint("final");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
